// File: rtl/eggtimer_pkg.sv
// Shared egg-timer definitions: button FSM state encoding and the default tick
// constants used by the decoder and the control FSM.
package eggtimer_pkg;

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StPressed = 2'd1,
    StHeld    = 2'd2
  } btn_state_e;

  localparam int unsigned DEFAULT_LONG_TICKS   = 500;
  localparam int unsigned DEFAULT_REPEAT_TICKS = 100;

endpackage

// File: rtl/button_event_decoder.sv
// Turns a debounced button level into press / short release / long press /
// long release / auto-repeat pulses, advancing only on the shared sample tick.
module button_event_decoder
  import eggtimer_pkg::*;
#(
  parameter int unsigned LONG_TICKS   = DEFAULT_LONG_TICKS,
  parameter int unsigned REPEAT_TICKS = DEFAULT_REPEAT_TICKS,
  parameter bit          REPEAT_EN    = 1'b1,
  parameter int unsigned CNT_W        = 10
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  input  logic level,
  output logic press,
  output logic short_rel,
  output logic long_press,
  output logic long_rel,
  // 'repeat' is a reserved word, hence the suffix
  output logic repeat_pulse,
  output logic held
);

  localparam longint unsigned CntRange = 64'd1 << CNT_W;

  if (CNT_W == 0 || CNT_W > 32 || CntRange <= 64'(LONG_TICKS) ||
      CntRange <= 64'(REPEAT_TICKS) || LONG_TICKS < 2 || REPEAT_TICKS < 1) begin : g_bad_params
    $error("button_event_decoder: CNT_W too narrow or tick parameters out of range");
  end

  localparam logic [CNT_W-1:0] LongLast   = CNT_W'(LONG_TICKS - 1);
  localparam logic [CNT_W-1:0] RepeatLast = CNT_W'(REPEAT_TICKS - 1);

  btn_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic press_q, press_d;
  logic short_rel_q, short_rel_d;
  logic long_press_q, long_press_d;
  logic long_rel_q, long_rel_d;
  logic repeat_q, repeat_d;
  logic held_q, held_d;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    press_d      = 1'b0;
    short_rel_d  = 1'b0;
    long_press_d = 1'b0;
    long_rel_d   = 1'b0;
    repeat_d     = 1'b0;

    if (enable) begin
      case (state_q)
        StIdle: begin
          if (level) begin
            press_d = 1'b1;
            cnt_d   = '0;
            state_d = StPressed;
          end
        end
        StPressed: begin
          // Release wins over an expiring count.
          if (!level) begin
            short_rel_d = 1'b1;
            cnt_d       = '0;
            state_d     = StIdle;
          end else if (cnt_q == LongLast) begin
            long_press_d = 1'b1;
            cnt_d        = '0;
            state_d      = StHeld;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        StHeld: begin
          if (!level) begin
            long_rel_d = 1'b1;
            cnt_d      = '0;
            state_d    = StIdle;
          end else if (cnt_q == RepeatLast) begin
            repeat_d = REPEAT_EN;
            cnt_d    = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        default: begin
          cnt_d   = '0;
          state_d = StIdle;
        end
      endcase
    end

    held_d = (state_d != StIdle);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      press_q      <= 1'b0;
      short_rel_q  <= 1'b0;
      long_press_q <= 1'b0;
      long_rel_q   <= 1'b0;
      repeat_q     <= 1'b0;
      held_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      press_q      <= press_d;
      short_rel_q  <= short_rel_d;
      long_press_q <= long_press_d;
      long_rel_q   <= long_rel_d;
      repeat_q     <= repeat_d;
      held_q       <= held_d;
    end
  end

  assign press        = press_q;
  assign short_rel    = short_rel_q;
  assign long_press   = long_press_q;
  assign long_rel     = long_rel_q;
  assign repeat_pulse = repeat_q;
  assign held         = held_q;

endmodule

// File: tb/tb_button_event_decoder.sv
// Scoreboard bench for button_event_decoder: two instances (repeat on/off)
// share directed stimulus; a monitor pops expected pulses and held levels.
module tb_button_event_decoder;

  localparam int unsigned LT = 4;
  localparam int unsigned RT = 2;
  localparam int unsigned CW = 3;

  // Pulse vector order: {press, short_rel, long_press, long_rel, repeat}
  localparam logic [4:0] EvNone = 5'b00000;
  localparam logic [4:0] EvP    = 5'b10000;
  localparam logic [4:0] EvS    = 5'b01000;
  localparam logic [4:0] EvL    = 5'b00100;
  localparam logic [4:0] EvLr   = 5'b00010;
  localparam logic [4:0] EvRp   = 5'b00001;

  typedef struct packed {
    logic [4:0]  v0;
    logic [4:0]  v1;
    logic [31:0] tick;
  } exp_t;

  logic clk = 1'b0;
  logic reset, enable, level;
  logic press0, srel0, lp0, lrel0, rpt0, held0;
  logic press1, srel1, lp1, lrel1, rpt1, held1;

  exp_t        sb[$];
  logic        hq[$];
  int unsigned tick_no = 0;
  logic        en_q = 1'b0;
  logic        done = 1'b0;
  logic        drained = 1'b0;
  int          checks = 0;
  int          errors = 0;
  logic [4:0]  prev0 = '0;
  logic [4:0]  prev1 = '0;

  button_event_decoder #(
    .LONG_TICKS(LT), .REPEAT_TICKS(RT), .REPEAT_EN(1'b1), .CNT_W(CW)
  ) u_dut_rep (
    .clk(clk), .reset(reset), .enable(enable), .level(level),
    .press(press0), .short_rel(srel0), .long_press(lp0), .long_rel(lrel0),
    .repeat_pulse(rpt0), .held(held0)
  );

  button_event_decoder #(
    .LONG_TICKS(LT), .REPEAT_TICKS(RT), .REPEAT_EN(1'b0), .CNT_W(CW)
  ) u_dut_norep (
    .clk(clk), .reset(reset), .enable(enable), .level(level),
    .press(press1), .short_rel(srel1), .long_press(lp1), .long_rel(lrel1),
    .repeat_pulse(rpt1), .held(held1)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    en_q <= enable;
    if (enable) tick_no <= tick_no + 1;
  end

  // One enable tick every third clock; glitch toggles level on the idle clocks.
  task automatic tick(input logic l, input logic [4:0] ev, input logic hexp,
                      input logic rst = 1'b0, input logic glitch = 1'b0);
    exp_t e;
    @(negedge clk);
    level  = l;
    enable = 1'b1;
    reset  = rst;
    if (ev != EvNone) begin
      e.v0   = ev;
      e.v1   = ev & ~EvRp;
      e.tick = tick_no + 1;
      sb.push_back(e);
    end
    hq.push_back(hexp);
    @(negedge clk);
    enable = 1'b0;
    reset  = 1'b0;
    if (glitch) level = ~l;
    @(negedge clk);
  endtask

  always @(negedge clk) begin
    logic [4:0] v0, v1;
    exp_t       e;
    logic       h;
    v0 = {press0, srel0, lp0, lrel0, rpt0};
    v1 = {press1, srel1, lp1, lrel1, rpt1};

    if (v0 != 5'b0 || v1 != 5'b0) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_pulse: tick %0d got rep=%b norep=%b, required none",
                 tick_no, v0, v1);
      end else begin
        e = sb.pop_front();
        if (e.v0 !== v0 || e.v1 !== v1 || e.tick != tick_no) begin
          errors++;
          $display("FAIL pulse: got rep=%b norep=%b at tick %0d, required rep=%b norep=%b at tick %0d",
                   v0, v1, tick_no, e.v0, e.v1, e.tick);
        end
      end
      checks++;
      if ($countones(v0) > 1 || $countones(v1) > 1) begin
        errors++;
        $display("FAIL one_hot: got rep=%b norep=%b, required at most one bit", v0, v1);
      end
    end

    if (prev0 != 5'b0 || prev1 != 5'b0) begin
      checks++;
      if (v0 != 5'b0 || v1 != 5'b0) begin
        errors++;
        $display("FAIL pulse_width: got rep=%b norep=%b one clk after a pulse, required 0",
                 v0, v1);
      end
    end
    prev0 = v0;
    prev1 = v1;

    if (en_q === 1'b1 && hq.size() != 0) begin
      h = hq.pop_front();
      checks++;
      if (held0 !== h || held1 !== h) begin
        errors++;
        $display("FAIL held: tick %0d got rep=%b norep=%b, required %b",
                 tick_no, held0, held1, h);
      end
    end

    if (done && !drained) begin
      drained = 1'b1;
      checks += 2;
      if (sb.size() != 0) begin
        errors++;
        $display("FAIL missing_pulses: got %0d outstanding, required 0", sb.size());
      end
      if (hq.size() != 0) begin
        errors++;
        $display("FAIL missing_held: got %0d outstanding, required 0", hq.size());
      end
    end
  end

  initial begin
    reset  = 1'b1;
    enable = 1'b0;
    level  = 1'b1;
    repeat (3) @(negedge clk);

    // Reset held with level=1 through an enable tick, then press on first tick.
    tick(1'b1, EvNone, 1'b0, 1'b1);
    tick(1'b1, EvP, 1'b1);
    // Short tap continues: one more held tick, then release.
    tick(1'b1, EvNone, 1'b1);
    tick(1'b0, EvS, 1'b0);
    tick(1'b0, EvNone, 1'b0);

    // Long hold for 10 ticks with repeats, then long release.
    tick(1'b1, EvP, 1'b1);
    for (int i = 1; i <= 9; i++) begin
      if (i == 4)                tick(1'b1, EvL, 1'b1);
      else if (i == 6 || i == 8) tick(1'b1, EvRp, 1'b1);
      else                       tick(1'b1, EvNone, 1'b1);
    end
    tick(1'b0, EvLr, 1'b0);
    tick(1'b0, EvNone, 1'b0);

    // Release exactly as the long count would expire.
    tick(1'b1, EvP, 1'b1);
    for (int i = 1; i <= 3; i++) tick(1'b1, EvNone, 1'b1);
    tick(1'b0, EvS, 1'b0);

    // Level toggles between strobes must be ignored.
    tick(1'b0, EvNone, 1'b0, 1'b0, 1'b1);
    tick(1'b0, EvNone, 1'b0, 1'b0, 1'b1);
    tick(1'b1, EvP, 1'b1, 1'b0, 1'b1);
    for (int i = 1; i <= 3; i++) tick(1'b1, EvNone, 1'b1, 1'b0, 1'b1);
    tick(1'b1, EvL, 1'b1, 1'b0, 1'b1);
    tick(1'b0, EvLr, 1'b0, 1'b0, 1'b1);
    tick(1'b0, EvNone, 1'b0);

    // Reset in HELD at t7: no release pulse afterwards.
    tick(1'b1, EvP, 1'b1);
    for (int i = 1; i <= 6; i++) begin
      if (i == 4)      tick(1'b1, EvL, 1'b1);
      else if (i == 6) tick(1'b1, EvRp, 1'b1);
      else             tick(1'b1, EvNone, 1'b1);
    end
    tick(1'b1, EvNone, 1'b0, 1'b1);
    tick(1'b0, EvNone, 1'b0);
    tick(1'b0, EvNone, 1'b0);

    done = 1'b1;
    repeat (4) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
